modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter MSB, default 7: operand MSB index; operands are MSB+1 bits wide.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: enable  in  1  block enable; low aborts and idles.
REQ-005 SHALL have ports: req  in  1  toggle-style start request.
REQ-006 SHALL have ports: ack  out  1  one-cycle done pulse.
REQ-007 SHALL have ports: base, exp, modulus  in  MSB+1 each  operands, sampled at start.
REQ-008 SHALL have ports: result  out  MSB+1  base^exp mod modulus.
REQ-009 SHALL have ports: err  out  1  modulus==0 on the last run; overrun  out  1  sticky dropped-request flag.
REQ-010 SHALL have ports: cst, nst  out  3 each  current and next state codes.
REQ-011 SHALL have remainder-unit ports: rem_req  out  1  toggle; rem_ack  in  1  completion pulse; rem_rx_data_1  out  2*(MSB+1)  dividend; rem_rx_data_2  out  MSB+1  divisor; rem_tx_data  in  MSB+1  remainder; rem_enable  out  1.

Function
REQ-012 SHALL detect a start when req differs from its registered copy while cst==IDLE and enable==1.
REQ-013 SHALL latch base, exp and modulus on the start cycle; later input changes have no effect until the next start.
REQ-014 SHALL use states IDLE=0, REDUCE=1, SQR=2, MUL=3, DONE=4; codes 5-7 SHALL return to IDLE.
REQ-015 SHALL issue each remainder operation as one toggle of rem_req with rem_rx_data_1/2 stable from that toggle until rem_ack.
REQ-016 SHALL treat rem_ack high for one cycle as completion, capture rem_tx_data in that cycle, and issue at most one outstanding operation.
REQ-017 REDUCE: dividend = zero-extended base, divisor = modulus; the result becomes b.
REQ-018 SHALL initialise accumulator r=1 and bit index i=MSB on entry to SQR.
REQ-019 SQR: dividend = r*r as an unsigned full 2*(MSB+1)-bit product; r <= remainder; go to MUL if exp[i]=1, else continue the loop.
REQ-020 MUL: dividend = r*b as a full product; r <= remainder; continue the loop.
REQ-021 Loop continue: if i==0 go to DONE, else decrement i and go to SQR.
REQ-022 Every exponent bit from MSB down to 0 SHALL be processed, including leading zeros. Remainder operations per run = 1 + (MSB+1) + popcount(exp).
REQ-023 DONE: result <= r; ack high exactly one cycle; return to IDLE next cycle.
REQ-024 A start with modulus==0 SHALL go directly to DONE with no remainder operation, result=0 and err=1; any other start clears err.
REQ-025 modulus==1 SHALL produce result=0. exp==0 SHALL produce result = 1 mod modulus.
REQ-026 A req toggle while not IDLE SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-027 rem_enable SHALL equal enable.
REQ-028 enable low in any state SHALL go to IDLE next cycle with no ack; result SHALL hold its previous value; a late rem_ack SHALL be ignored.
REQ-029 result SHALL change only in DONE.

Reset
REQ-030 On rstn low, immediately and asynchronously: cst=IDLE, ack=0, result=0, err=0, overrun=0, rem_req=0, rem_rx_data_1/2=0, and the req copy=0.
REQ-031 A reset mid-operation SHALL abandon the run; no ack SHALL follow.

Structure
REQ-032 State codes and the operation-count function SHALL live in shared package rsa_pkg.
REQ-033 The multiplier SHALL be a sub-module modexp_mul: combinational, (MSB+1)x(MSB+1) to 2*(MSB+1) unsigned.
REQ-034 The bench SHALL pair the block with the existing remainder unit, using the same req/ack toggle convention.

Verification
REQ-035 base=4, exp=13, modulus=97 -> result=93, err=0, 1+8+3=12 rem ops, one ack.
REQ-036 base=200, exp=1, modulus=13 -> 5; base=3, exp=0, modulus=7 -> 1; base=9, exp=5, modulus=1 -> 0.
REQ-037 modulus=0 -> ack within 3 cycles of the toggle, result=0, err=1, zero rem_req toggles.
REQ-038 base=255, exp=255, modulus=255 -> 0; then base=254, exp=255, modulus=255 -> 254 (254 = -1 mod 255, and exp is odd).
REQ-039 A toggle of req mid-run -> overrun=1, exactly one ack, no second run.
REQ-040 Drop enable or assert rstn during SQR -> IDLE, no ack; a subsequent start yields the correct result.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation controller.
package rsa_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REDUCE = 3'd1,
      SQR    = 3'd2,
      MUL    = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Remainder operations needed for one run: the base reduction, one
   // square per exponent bit, and one multiply per set exponent bit.
   function automatic int rem_op_count(input logic [31:0] e, input int width);
      int n;
      n = 1 + width;
      for (int k = 0; k < 32; k++) begin
         if (k < width) n += int'(e[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/modexp_ctrl_if.sv
// Toggle-handshake link between the controller and the remainder unit.
interface modexp_ctrl_if #(parameter int MSB = 7);
   logic                 rem_req;
   logic                 rem_ack;
   logic [2*(MSB+1)-1:0] rem_rx_data_1;
   logic [MSB:0]         rem_rx_data_2;
   logic [MSB:0]         rem_tx_data;
   logic                 rem_enable;

   modport master (
      output rem_req, rem_rx_data_1, rem_rx_data_2, rem_enable,
      input  rem_ack, rem_tx_data
   );

   modport slave (
      input  rem_req, rem_rx_data_1, rem_rx_data_2, rem_enable,
      output rem_ack, rem_tx_data
   );
endinterface

// File: rtl/modexp_ctrl_mul.sv
// Unsigned full-width combinational multiplier.
module modexp_mul #(
   parameter int MSB = 7
) (
   input  logic [MSB:0]         a,
   input  logic [MSB:0]         b,
   output logic [2*(MSB+1)-1:0] p
);
   localparam int W = MSB + 1;

   // Zero-extend both operands so the product keeps every bit.
   assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

// File: rtl/modexp_ctrl.sv
// Square-and-multiply controller for base^exp mod modulus, using an
// external remainder unit over a toggle req/ack link.
//
// state  | meaning
// IDLE   | waiting for a req toggle
// REDUCE | b = base mod modulus
// SQR    | r = r*r mod modulus for exponent bit i
// MUL    | r = r*b mod modulus when exponent bit i is set
// DONE   | publish result, pulse ack
module modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int MSB = 7
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          enable,
   input  logic          req,
   output logic          ack,
   input  logic [MSB:0]  base,
   input  logic [MSB:0]  exp,
   input  logic [MSB:0]  modulus,
   output logic [MSB:0]  result,
   output logic          err,
   output logic          overrun,
   output logic [2:0]    cst,
   output logic [2:0]    nst,
   modexp_ctrl_if.master rem
);
   localparam int W  = MSB + 1;
   localparam int IW = (MSB > 0) ? $clog2(MSB + 1) : 1;

   state_t            state_q, state_d;
   logic              req_q;
   logic              toggle, start;
   logic              pend, issue, op_done;
   logic [MSB:0]      base_q, exp_q, mod_q, b_q, r_q, mul_b;
   logic [IW-1:0]     i_q;
   logic [2*W-1:0]    prod, dividend;

   assign toggle  = req ^ req_q;
   assign start   = toggle && (state_q == IDLE) && enable;
   assign op_done = pend && rem.rem_ack;
   assign issue   = enable && !pend &&
                    ((state_q == REDUCE) || (state_q == SQR) || (state_q == MUL));

   assign cst            = state_q;
   assign nst            = state_d;
   assign rem.rem_enable = enable;

   assign mul_b    = (state_q == MUL) ? b_q : r_q;
   assign dividend = (state_q == REDUCE) ? {{W{1'b0}}, base_q} : prod;

   modexp_mul #(.MSB(MSB)) u_mul (
      .a (r_q),
      .b (mul_b),
      .p (prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; a step only advances once its remainder result is back.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = (modulus == '0) ? DONE : REDUCE;
            REDUCE:  if (op_done) state_d = SQR;
            SQR:     if (op_done) begin
                        if (exp_q[i_q])       state_d = MUL;
                        else if (i_q == '0)   state_d = DONE;
                        else                  state_d = SQR;
                     end
            MUL:     if (op_done) state_d = (i_q == '0) ? DONE : SQR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Operand capture, remainder handshake, accumulator and status flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         req_q             <= 1'b0;
         ack               <= 1'b0;
         result            <= '0;
         err               <= 1'b0;
         overrun           <= 1'b0;
         pend              <= 1'b0;
         base_q            <= '0;
         exp_q             <= '0;
         mod_q             <= '0;
         b_q               <= '0;
         r_q               <= '0;
         i_q               <= '0;
         rem.rem_req       <= 1'b0;
         rem.rem_rx_data_1 <= '0;
         rem.rem_rx_data_2 <= '0;
      end else begin
         req_q <= req;
         ack   <= 1'b0;
         if (toggle && (state_q != IDLE)) overrun <= 1'b1;
         if (!enable) begin
            // Abandon any outstanding operation so a late rem_ack is ignored.
            pend <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     base_q <= base;
                     exp_q  <= exp;
                     mod_q  <= modulus;
                     err    <= (modulus == '0);
                     r_q    <= '0;
                  end
               end
               REDUCE, SQR, MUL: begin
                  if (issue) begin
                     rem.rem_req       <= ~rem.rem_req;
                     rem.rem_rx_data_1 <= dividend;
                     rem.rem_rx_data_2 <= mod_q;
                     pend              <= 1'b1;
                  end else if (op_done) begin
                     pend <= 1'b0;
                     if (state_q == REDUCE) begin
                        b_q <= rem.rem_tx_data;
                        r_q <= W'(1);
                        i_q <= IW'(MSB);
                     end else begin
                        r_q <= rem.rem_tx_data;
                        // A SQR that moves on to MUL keeps the same bit index.
                        if (i_q != '0 && !(state_q == SQR && exp_q[i_q]))
                           i_q <= i_q - 1'b1;
                     end
                  end
               end
               DONE: begin
                  result <= r_q;
                  ack    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl paired with a behavioural remainder unit.
module tb_modexp_ctrl;
   localparam int MSB = 7;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       enable = 1'b0;
   logic       req = 1'b0;
   logic       ack;
   logic [7:0] base = '0, exp = '0, modulus = '0;
   logic [7:0] result;
   logic       err, overrun;
   logic [2:0] cst, nst;

   int checks = 0;
   int errors = 0;

   modexp_ctrl_if #(.MSB(MSB)) rem_if ();

   modexp_ctrl #(.MSB(MSB)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .enable  (enable),
      .req     (req),
      .ack     (ack),
      .base    (base),
      .exp     (exp),
      .modulus (modulus),
      .result  (result),
      .err     (err),
      .overrun (overrun),
      .cst     (cst),
      .nst     (nst),
      .rem     (rem_if)
   );

   always #5 clk = ~clk;

   // Remainder unit: toggle in, fixed latency, one-cycle ack with the remainder.
   logic        rq_q, busy;
   logic [1:0]  lat;
   logic [15:0] d1;
   logic [7:0]  d2;
   int          nops = 0;
   int          overlap = 0;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rq_q               <= 1'b0;
         busy               <= 1'b0;
         lat                <= '0;
         d1                 <= '0;
         d2                 <= '0;
         rem_if.rem_ack     <= 1'b0;
         rem_if.rem_tx_data <= '0;
      end else begin
         rem_if.rem_ack <= 1'b0;
         rq_q           <= rem_if.rem_req;
         if (!rem_if.rem_enable) begin
            busy <= 1'b0;
         end else if (rem_if.rem_req != rq_q) begin
            if (busy) overlap <= overlap + 1;
            busy <= 1'b1;
            lat  <= 2'd2;
            d1   <= rem_if.rem_rx_data_1;
            d2   <= rem_if.rem_rx_data_2;
            nops <= nops + 1;
         end else if (busy) begin
            if (lat == 2'd0) begin
               busy               <= 1'b0;
               rem_if.rem_ack     <= 1'b1;
               rem_if.rem_tx_data <= (d2 == 8'd0) ? 8'd0 : 8'(d1 % {8'd0, d2});
            end else begin
               lat <= lat - 2'd1;
            end
         end
      end
   end

   int nacks = 0;
   always @(posedge clk) if (ack) nacks <= nacks + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic kick(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
      @(negedge clk);
      base = b; exp = e; modulus = m;
      req = ~req;
      @(negedge clk);
      // Scramble operands after the start cycle; they must already be latched.
      base = ~b; exp = ~e; modulus = m + 8'd3;
   endtask

   task automatic wait_ack(input string tag, output int cyc);
      bit seen;
      seen = 0;
      cyc  = 1;
      for (int k = 0; k < 2000 && !seen; k++) begin
         if (ack) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic run(input string tag, input logic [7:0] b, input logic [7:0] e,
                      input logic [7:0] m, input logic [7:0] want_res,
                      input logic want_err, input int want_ops);
      int ops0, acks0, cyc;
      ops0  = nops;
      acks0 = nacks;
      kick(b, e, m);
      wait_ack(tag, cyc);
      chk({tag, "_result"}, 32'(result), 32'(want_res));
      chk({tag, "_err"}, 32'(err), 32'(want_err));
      if (m == 8'd0) chk({tag, "_latency_le3"}, 32'(cyc <= 3), 32'd1);
      repeat (20) @(negedge clk);
      chk({tag, "_ops"}, 32'(nops - ops0), 32'(want_ops));
      chk({tag, "_acks"}, 32'(nacks - acks0), 32'd1);
      chk({tag, "_idle"}, 32'(cst), 32'd0);
   endtask

   task automatic wait_sqr(input string tag);
      bit seen;
      seen = 0;
      for (int k = 0; k < 500 && !seen; k++) begin
         @(negedge clk);
         if (cst == 3'd2) seen = 1;
      end
      chk({tag, "_reached_sqr"}, 32'(seen), 32'd1);
   endtask

   initial begin
      int acks0, ops0, cyc;

      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_cst", 32'(cst), 32'd0);
      chk("rst_rem_req", 32'(rem_if.rem_req), 32'd0);
      chk("rst_rx1", 32'(rem_if.rem_rx_data_1), 32'd0);
      repeat (3) @(negedge clk);
      rstn   = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("rem_enable_hi", 32'(rem_if.rem_enable), 32'd1);

      run("r4_13_97",   8'd4,   8'd13,  8'd97,  8'd93,  1'b0, 12);
      run("r200_1_13",  8'd200, 8'd1,   8'd13,  8'd5,   1'b0, 10);
      run("r3_0_7",     8'd3,   8'd0,   8'd7,   8'd1,   1'b0, 9);
      run("r9_5_1",     8'd9,   8'd5,   8'd1,   8'd0,   1'b0, 11);
      run("r5_3_0",     8'd5,   8'd3,   8'd0,   8'd0,   1'b1, 0);
      run("r255_255",   8'd255, 8'd255, 8'd255, 8'd0,   1'b0, 17);
      run("r254_255",   8'd254, 8'd255, 8'd255, 8'd254, 1'b0, 17);

      // Request toggle in the middle of a run.
      acks0 = nacks;
      ops0  = nops;
      kick(8'd4, 8'd13, 8'd97);
      repeat (8) @(negedge clk);
      req = ~req;
      wait_ack("ovr", cyc);
      chk("ovr_result", 32'(result), 32'd93);
      repeat (100) @(negedge clk);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_acks", 32'(nacks - acks0), 32'd1);
      chk("ovr_ops", 32'(nops - ops0), 32'd12);
      chk("ovr_idle", 32'(cst), 32'd0);

      // Drop enable during SQR.
      run("pre_en", 8'd200, 8'd1, 8'd13, 8'd5, 1'b0, 10);
      acks0 = nacks;
      kick(8'd4, 8'd13, 8'd97);
      wait_sqr("en");
      enable = 1'b0;
      @(negedge clk);
      chk("en_idle", 32'(cst), 32'd0);
      chk("en_rem_enable", 32'(rem_if.rem_enable), 32'd0);
      repeat (20) @(negedge clk);
      chk("en_no_ack", 32'(nacks - acks0), 32'd0);
      chk("en_result_held", 32'(result), 32'd5);
      enable = 1'b1;
      repeat (5) @(negedge clk);
      run("post_en", 8'd4, 8'd13, 8'd97, 8'd93, 1'b0, 12);

      // Reset during SQR.
      acks0 = nacks;
      kick(8'd3, 8'd0, 8'd7);
      wait_sqr("rst");
      rstn = 1'b0;
      req  = 1'b0;
      #1;
      chk("mid_rst_cst", 32'(cst), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      chk("mid_rst_rem_req", 32'(rem_if.rem_req), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_no_ack", 32'(nacks - acks0), 32'd0);
      run("post_rst", 8'd4, 8'd13, 8'd97, 8'd93, 1'b0, 12);

      chk("rem_overlap", 32'(overlap), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
endmodule
